// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one main-memory port between the data cache (requester 0, read/write)
// and instruction fetch (requester 1, read-only). Each access is a fixed-latency
// transaction: latch the winning request, drive memory for MEM_LATENCY cycles,
// capture the read data in the last access cycle, then pulse done for one cycle.
// Only one transaction is outstanding at a time.
//
// Ports
//   clk, reset               : clock and asynchronous active-high reset
//   req0_valid/we/addr/wdata : data-cache request (held until req0_done)
//   req0_done, req0_rdata    : one-cycle completion pulse and read data
//   req1_valid/addr          : fetch request (held until req1_done)
//   req1_done, req1_rdata    : one-cycle completion pulse and fetched word
//   mem_addr/wdata/we        : memory port drive
//   mem_rdata                : memory read data, valid in the last access cycle
//   busy                     : high while a transaction is in ACCESS or DONE
//   grant_id                 : requester being served (0 when idle)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int MEM_LATENCY = 4,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [31:0]       req0_wdata,
    output logic              req0_done,
    output logic [31:0]       req0_rdata,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_done,
    output logic [31:0]       req1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output logic              grant_id
);

    localparam int               CNT_W    = $clog2(MEM_LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t              state_q,      state_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic                last_grant_q, last_grant_d;
    logic                grant_id_q,   grant_id_d;
    logic                we_q,         we_d;
    logic [ADDR_W-1:0]   addr_q,       addr_d;
    logic [31:0]         wdata_q,      wdata_d;
    logic [31:0]         rdata0_q,     rdata0_d;
    logic [31:0]         rdata1_q,     rdata1_d;
    logic                mem_we_q,     mem_we_d;
    logic                busy_q,       busy_d;
    logic                done0_q,      done0_d;
    logic                done1_q,      done1_d;
    logic                win_id;

    // Next-state, request latching and next-cycle output computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        win_id       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Round-robin only decides ties; a lone requester just wins.
                if (req0_valid && req1_valid) begin
                    win_id       = ~last_grant_q;
                    last_grant_d = ~last_grant_q;
                end else if (req1_valid) begin
                    win_id = 1'b1;
                end else begin
                    win_id = 1'b0;
                end

                if (req0_valid || req1_valid) begin
                    grant_id_d = win_id;
                    cnt_d      = CNT_LOAD;
                    state_d    = ST_ACCESS;
                    if (win_id) begin
                        // Fetch is read-only and carries no write data.
                        addr_d  = req1_addr;
                        we_d    = 1'b0;
                        wdata_d = 32'h0000_0000;
                    end else begin
                        addr_d  = req0_addr;
                        we_d    = req0_we;
                        wdata_d = req0_wdata;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ACCESS: begin
                if (cnt_q == CNT_ZERO) begin
                    // Last access cycle: memory data is valid now. Writes
                    // return zero so stale read data never leaks out.
                    state_d = ST_DONE;
                    if (grant_id_q) begin
                        rdata1_d = we_q ? 32'h0000_0000 : mem_rdata;
                    end else begin
                        rdata0_d = we_q ? 32'h0000_0000 : mem_rdata;
                    end
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                    state_d = ST_ACCESS;
                end
            end

            ST_DONE: begin
                state_d    = ST_IDLE;
                grant_id_d = 1'b0;
            end

            default: begin
                state_d    = ST_IDLE;
                grant_id_d = 1'b0;
                cnt_d      = CNT_ZERO;
            end
        endcase

        // Outputs are precomputed from the next state so they leave flops
        // and line up with the cycle they describe.
        mem_we_d = (state_d == ST_ACCESS) && (cnt_d == CNT_ZERO) && we_d;
        busy_d   = (state_d != ST_IDLE);
        done0_d  = (state_d == ST_DONE) && !grant_id_d;
        done1_d  = (state_d == ST_DONE) && grant_id_d;
    end

    // State and output registers; last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= CNT_ZERO;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= {ADDR_W{1'b0}};
            wdata_q      <= 32'h0000_0000;
            rdata0_q     <= 32'h0000_0000;
            rdata1_q     <= 32'h0000_0000;
            mem_we_q     <= 1'b0;
            busy_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            mem_we_q     <= mem_we_d;
            busy_q       <= busy_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
        end
    end

    assign req0_done  = done0_q;
    assign req1_done  = done1_q;
    assign req0_rdata = rdata0_q;
    assign req1_rdata = rdata1_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_we     = mem_we_q;
    assign busy       = busy_q;
    assign grant_id   = grant_id_q;

endmodule
